// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate generator with elastic registered output
//
// Decodes the immediate field of an instruction (bits [31:7]) for the format
// chosen by sel, sign-extends it to XLEN and queues it behind a valid/ready
// output stage.
//
// Parameters
//   XLEN     immediate width, 32 or 64
//   SKID_EN  1: two-entry elastic buffer, full throughput
//            0: single register, in_ready = !out_valid | out_ready
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   instr/sel valid
//   in_ready   block accepts input
//   instr      instruction bits [31:7]
//   sel        000 I, 001 S, 010 B, 011 U, 100 J, others illegal
//   flush      discard every held entry and any input of this cycle
//   out_valid  imm_ext/fmt_err valid
//   out_ready  consumer accepts output
//   imm_ext    sign-extended immediate (0 for illegal sel)
//   fmt_err    entry carried an illegal sel

module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            fmt_err
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic            main_err_q, main_err_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_err_q, skid_err_d;
    logic            in_ready_q, in_ready_d;

    logic [31:7]     w;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic            in_fire;
    logic            out_fire;

    // Re-index so the slices below read with architectural bit numbers.
    assign w = instr;

    always_comb begin
        dec_imm32 = '0;
        dec_err   = 1'b0;
        case (sel)
            3'b000:  dec_imm32 = {{20{w[31]}}, w[31:20]};
            3'b001:  dec_imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
            3'b010:  dec_imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'b011:  dec_imm32 = {w[31:12], 12'b0};
            3'b100:  dec_imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: dec_err   = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign dec_imm = {{32{dec_imm32[31]}}, dec_imm32};
        end else begin : g_xlen32
            assign dec_imm = dec_imm32;
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register (also holds the data entries).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_imm_q <= '0;
            main_err_q <= 1'b0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_err_q <= main_err_d;
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state. With SKID_EN=0 in_ready already excludes "input only" while
    // in ONE, so TWO is never entered and the same transitions apply.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_err_d = main_err_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d    = ST_ONE;
                    main_imm_d = dec_imm;
                    main_err_d = dec_err;
                end
            end
            ST_ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d    = ST_TWO;
                        skid_imm_d = dec_imm;
                        skid_err_d = dec_err;
                    end
                    2'b01: state_d = ST_EMPTY;
                    2'b11: begin
                        main_imm_d = dec_imm;
                        main_err_d = dec_err;
                    end
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d    = ST_ONE;
                    main_imm_d = skid_imm_q;
                    main_err_d = skid_err_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        // Registered ready: known a cycle ahead, so no out_ready->in_ready path.
        in_ready_d = (state_d != ST_TWO);
    end

    // Outputs, all taken from registered state.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = SKID_EN ? in_ready_q : (!out_valid | out_ready);
        imm_ext   = main_imm_q;
        fmt_err   = main_err_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and random checks of imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [24:0] instr = '0;
    logic [2:0]  sel = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, err_a;
    logic [31:0] imm_a;
    logic        in_ready_b, out_valid_b, err_b;
    logic [63:0] imm_b;
    logic        in_ready_c, out_valid_c, err_c;
    logic [31:0] imm_c;

    int n_pass = 0;
    int n_total = 0;
    int acc_a = 0, acc_b = 0, acc_c = 0;
    logic [64:0] q_a[$], q_b[$], q_c[$];

    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .sel(sel), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .imm_ext(imm_a), .fmt_err(err_a));

    imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .sel(sel), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .imm_ext(imm_b), .fmt_err(err_b));

    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .instr(instr), .sel(sel), .flush(flush), .out_valid(out_valid_c),
        .out_ready(out_ready), .imm_ext(imm_c), .fmt_err(err_c));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {fmt_err, 64-bit immediate}, built with arithmetic shifts.
    function automatic logic [64:0] ref_imm(input logic [31:0] wd, input logic [2:0] s);
        logic signed [31:0] sw;
        logic signed [63:0] x;
        sw = wd;
        x  = sw;
        case (s)
            3'd0: x = x >>> 20;
            3'd1: begin x = x >>> 25; x = x <<< 5; x[4:0] = wd[11:7]; end
            3'd2: begin
                x = x >>> 31; x[11] = wd[7]; x[10:5] = wd[30:25];
                x[4:1] = wd[11:8]; x[0] = 1'b0;
            end
            3'd3: x[11:0] = '0;
            3'd4: begin
                x = x >>> 31; x[19:12] = wd[19:12]; x[11] = wd[20];
                x[10:1] = wd[30:21]; x[0] = 1'b0;
            end
            default: x = '0;
        endcase
        return {(s > 3'd4), x};
    endfunction

    task automatic drive(input logic v, input logic [31:0] wd, input logic [2:0] s);
        in_valid = v;
        instr    = wd[31:7];
        sel      = s;
    endtask

    task automatic vec(input string tag, input logic [31:0] wd, input logic [2:0] s,
                       input logic [31:0] e32, input logic [63:0] e64, input logic e_err);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, wd, s);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, {63'b0, out_valid_a}, 64'd1);
        chk({tag, "_imm32"}, {32'b0, imm_a}, {32'b0, e32});
        chk({tag, "_err"}, {63'b0, err_a}, {63'b0, e_err});
        chk({tag, "_imm64"}, imm_b, e64);
        chk({tag, "_imm32_noskid"}, {32'b0, imm_c}, {32'b0, e32});
    endtask

    // One random cycle: drive, settle, pop any output transfer, push any input transfer.
    task automatic step_random(input bit gen_in);
        logic [31:0] wd;
        logic [64:0] e;
        wd = $urandom;
        drive(gen_in && ($urandom_range(0, 9) < 7), wd, 3'($urandom_range(0, 7)));
        out_ready = ($urandom_range(0, 9) < 7) || !gen_in;
        #1;
        if (out_valid_a && out_ready) begin
            if (q_a.size() == 0) chk("rnd_a_extra", 64'(q_a.size()), 64'd1);
            else begin
                e = q_a.pop_front();
                chk("rnd_a", {31'b0, err_a, imm_a}, {31'b0, e[64], e[31:0]});
            end
        end
        if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) chk("rnd_b_extra", 64'(q_b.size()), 64'd1);
            else begin
                e = q_b.pop_front();
                chk("rnd_b_imm", imm_b, e[63:0]);
                chk("rnd_b_err", {63'b0, err_b}, {63'b0, e[64]});
            end
        end
        if (out_valid_c && out_ready) begin
            if (q_c.size() == 0) chk("rnd_c_extra", 64'(q_c.size()), 64'd1);
            else begin
                e = q_c.pop_front();
                chk("rnd_c", {31'b0, err_c, imm_c}, {31'b0, e[64], e[31:0]});
            end
        end
        e = ref_imm({instr, 7'b0}, sel);
        if (in_valid && in_ready_a) begin q_a.push_back(e); acc_a++; end
        if (in_valid && in_ready_b) begin q_b.push_back(e); acc_b++; end
        if (in_valid && in_ready_c) begin q_c.push_back(e); acc_c++; end
        @(negedge clk);
    endtask

    initial begin
        int n_in, n_out, cyc;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {63'b0, out_valid_a}, 64'd0);
        chk("rst_ready", {63'b0, in_ready_a}, 64'd1);
        chk("rst_imm", {32'b0, imm_a}, 64'd0);
        chk("rst_err", {63'b0, err_a}, 64'd0);
        chk("rst_ready_noskid", {63'b0, in_ready_c}, 64'd1);
        chk("rst_imm64", imm_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Format decode
        vec("i_type", 32'hFFC4A303, 3'd0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        vec("s_type", 32'h0064A423, 3'd1, 32'h00000008, 64'h0000000000000008, 1'b0);
        vec("b_type", 32'hFE420AE3, 3'd2, 32'hFFFFFFF4, 64'hFFFFFFFFFFFFFFF4, 1'b0);
        vec("u_type", 32'h123452B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0);
        vec("j_type", 32'h008000EF, 3'd4, 32'h00000008, 64'h0000000000000008, 1'b0);
        vec("illegal", 32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1);
        vec("u_neg", 32'h800002B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        @(negedge clk);
        chk("drain_valid", {63'b0, out_valid_a}, 64'd0);

        // Skid fill and ordered drain
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC4A303, 3'd0);
        @(negedge clk);
        chk("skid_ready_one", {63'b0, in_ready_a}, 64'd1);
        chk("skid_a_first", {32'b0, imm_a}, 64'hFFFFFFFC);
        chk("noskid_ready_full", {63'b0, in_ready_c}, 64'd0);
        drive(1'b1, 32'h0064A423, 3'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("skid_ready_two", {63'b0, in_ready_a}, 64'd0);
        chk("skid_a_held", {32'b0, imm_a}, 64'hFFFFFFFC);
        @(negedge clk);
        chk("skid_a_stable", {32'b0, imm_a}, 64'hFFFFFFFC);
        chk("skid_valid_stable", {63'b0, out_valid_a}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid_b_next", {32'b0, imm_a}, 64'h8);
        chk("skid_ready_after_a", {63'b0, in_ready_a}, 64'd1);
        @(negedge clk);
        chk("skid_empty", {63'b0, out_valid_a}, 64'd0);

        // Flush in TWO with a presented input
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC4A303, 3'd0);
        @(negedge clk);
        drive(1'b1, 32'h0064A423, 3'd1);
        @(negedge clk);
        chk("flush_pre_two", {63'b0, in_ready_a}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h123452B7, 3'd3);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_two_valid", {63'b0, out_valid_a}, 64'd0);
        chk("flush_two_ready", {63'b0, in_ready_a}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_two_quiet", {63'b0, out_valid_a}, 64'd0);
        end

        // Flush in ONE while an input is actually accepted
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC4A303, 3'd0);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h008000EF, 3'd4);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", {63'b0, out_valid_a}, 64'd0);
        @(negedge clk);
        chk("flush_one_quiet", {63'b0, out_valid_a}, 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h0064A423, 3'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_flush_first", {31'b0, out_valid_a, imm_a}, {31'b0, 1'b1, 32'h8});

        // Asynchronous reset with an entry held
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC4A303, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", {63'b0, out_valid_a}, 64'd0);
        chk("areset_imm", {32'b0, imm_a}, 64'd0);
        chk("areset_ready", {63'b0, in_ready_a}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h123452B7, 3'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("areset_first_out", {31'b0, out_valid_a, imm_a}, {31'b0, 1'b1, 32'h12345000});
        @(negedge clk);

        // Full throughput with skid enabled
        n_in = 0;
        n_out = 0;
        out_ready = 1'b1;
        drive(1'b1, 32'h008000EF, 3'd4);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready_a) n_in++;
            if (out_valid_a) n_out++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("tput_in", 64'(n_in), 64'd50);
        chk("tput_out", 64'(n_out), 64'd49);

        // Random traffic against the reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while ((acc_a < 1000 || acc_b < 1000 || acc_c < 1000) && cyc < 6000) begin
            step_random(1'b1);
            cyc++;
        end
        for (int i = 0; i < 4; i++) step_random(1'b0);
        chk("rnd_acc_a", {63'b0, acc_a >= 1000}, 64'd1);
        chk("rnd_acc_b", {63'b0, acc_b >= 1000}, 64'd1);
        chk("rnd_acc_c", {63'b0, acc_c >= 1000}, 64'd1);
        chk("rnd_left_a", 64'(q_a.size()), 64'd0);
        chk("rnd_left_b", 64'(q_b.size()), 64'd0);
        chk("rnd_left_c", 64'(q_c.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
